mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory-side responder for the CPU pipeline. It serves instruction fetches from IF and load/store requests from the MEM stage over a single byte-wide synchronous RAM port.
- It arbitrates between the two requesters, serializes 1/2/4-byte accesses into byte cycles, assembles little-endian read data with sign/zero extension, and returns a one-cycle done pulse to the winning requester.

Parameters:
- ADDR_W, 17, width of the RAM address bus (RAM byte space is 2^ADDR_W).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset; asynchronous, active-low.
- if_req_in  input  1  fetch request; held high until if_done_out has been seen.
- if_addr_in  input  32  fetch byte address.
- if_done_out  output  1  one-cycle pulse; fetch data valid.
- if_data_out  output  32  fetched instruction word.
- mem_req_in  input  1  load/store request; held high until mem_done_out has been seen.
- mem_we_in  input  1  1 = store, 0 = load.
- mem_size_in  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- mem_signed_in  input  1  load sign-extends when 1.
- mem_addr_in  input  32  access byte address.
- mem_wdata_in  input  32  store data; low bytes used.
- mem_done_out  output  1  one-cycle pulse; load data valid or store complete.
- mem_rdata_out  output  32  extended load data.
- ram_din_in  input  8  RAM read byte; valid in the cycle after its address is registered by the RAM.
- ram_dout_out  output  8  RAM write byte.
- ram_a_out  output  ADDR_W  RAM byte address.
- ram_wr_out  output  1  1 = write this cycle.

Behaviour:
- Timing notation: edge Ek ends cycle k-1; cycle k is the interval after Ek.
- Reset:
  - While rst_in is low, every output is 0 and the FSM is in IDLE.
  - Reset asserted mid-access aborts the access immediately: no done pulse, no further RAM writes. Partial store bytes already written remain.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Requests are sampled at edge E0.
  - mem_req_in has priority over if_req_in when both are high.
  - On acceptance, latch address, size, signed, wdata, and the owner (IF or MEM).
  - Byte count n: IF = 4; MEM = 1, 2 or 4 by size.
  - Go to READ, or to WRITE for a MEM store.
  - Input changes after acceptance are ignored.
- READ:
  - Cycles 0..n-1: ram_a_out = latched address + i (low ADDR_W bits, wrapping modulo 2^ADDR_W); ram_wr_out = 0.
  - Byte i is captured from ram_din_in at edge E(i+2) into lane i (little-endian).
  - At E(n+1): go to DONE and register the output data.
    - MEM byte loads: bits above 7 are filled with bit 7 if signed, else 0.
    - MEM half loads: bits above 15 are filled with bit 15 if signed, else 0.
  - Word load or fetch: done is high in cycle 5.
- WRITE:
  - Cycles 0..n-1: ram_wr_out = 1, ram_a_out = address + i, ram_dout_out = wdata byte i.
  - At En: go to DONE.
  - Word store: done is high in cycle 4.
- DONE (one cycle):
  - The owner's done output is high; the other requester's done stays 0.
  - ram_wr_out = 0.
  - Requests are ignored in this cycle. The requester drops its req at the edge ending DONE.
  - Next state is IDLE, so the earliest next acceptance is the edge ending the following IDLE cycle.
- Read data outputs:
  - Updated only at the completion edge of their own requester.
  - Hold their value otherwise.
- Outside READ/WRITE: ram_wr_out = 0; ram_a_out and ram_dout_out are 0.
- All outputs are registered.
- No alignment checks are performed; misaligned accesses proceed bytewise.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE/READ/WRITE/DONE).
  - Size codes (SIZE_B = 0, SIZE_H = 1, SIZE_W = 2).
  - Owner constants (OWN_IF, OWN_MEM).
- One natural sub-module, load_extend: purely combinational; takes the 32-bit assembled data, size and signed, and returns the extended value.

Test Plan:
- Reset: hold rst_in low with both reqs high -> all outputs 0, no RAM write. Release -> MEM served first.
- Load word: mem_req with word size at 0x100, RAM holds 11,22,33,44 -> ram_a_out 0x100..0x103 in cycles 0-3; mem_done_out high only in cycle 5; mem_rdata_out = 0x44332211.
- Loads at 0x80 = 0x80, 0x81 = 0x80:
  - Signed byte at 0x80 -> 0xFFFFFF80.
  - Unsigned half at 0x80 -> 0x00008080.
  - Signed half at 0x80 -> 0xFFFF8080.
- Store word: 0xDEADBEEF at 0x200 -> ram_wr_out high in cycles 0-3 with bytes EF, BE, AD, DE at 0x200..0x203; mem_done_out in cycle 4. A store byte writes only EF.
- Arbitration: if_req and mem_req rise together -> MEM access completes first with no if_done_out; the IF fetch is accepted at the edge after DONE+IDLE; if_data_out unaffected by the MEM load.
- Wrap and abort:
  - Word read at 0x1FFFF (ADDR_W = 17) -> addresses 0x1FFFF, 0x0, 0x1, 0x2.
  - Reset asserted in cycle 2 of a word read -> outputs 0 immediately, no done; the next request after release completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Size code 3 is served as a full word.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SIZE_B:  nbytes = 3'd1;
      SIZE_H:  nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM-port bundle; the controller sits on the slave modport.
interface mem_ctrl_if #(parameter int ADDR_W = 17);
  logic              if_req_in;
  logic [31:0]       if_addr_in;
  logic              if_done_out;
  logic [31:0]       if_data_out;
  logic              mem_req_in;
  logic              mem_we_in;
  logic [1:0]        mem_size_in;
  logic              mem_signed_in;
  logic [31:0]       mem_addr_in;
  logic [31:0]       mem_wdata_in;
  logic              mem_done_out;
  logic [31:0]       mem_rdata_out;
  logic [7:0]        ram_din_in;
  logic [7:0]        ram_dout_out;
  logic [ADDR_W-1:0] ram_a_out;
  logic              ram_wr_out;

  modport slave (
    input  if_req_in, if_addr_in, mem_req_in, mem_we_in, mem_size_in,
           mem_signed_in, mem_addr_in, mem_wdata_in, ram_din_in,
    output if_done_out, if_data_out, mem_done_out, mem_rdata_out,
           ram_dout_out, ram_a_out, ram_wr_out
  );

  modport master (
    output if_req_in, if_addr_in, mem_req_in, mem_we_in, mem_size_in,
           mem_signed_in, mem_addr_in, mem_wdata_in, ram_din_in,
    input  if_done_out, if_data_out, mem_done_out, mem_rdata_out,
           ram_dout_out, ram_a_out, ram_wr_out
  );
endinterface

// File: rtl/mem_ctrl_load_extend.sv
// Sign/zero extension of an assembled little-endian load value.
module mem_ctrl_load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (size_i)
      SIZE_B:  data_o = {{24{signed_i & data_i[7]}},  data_i[7:0]};
      SIZE_H:  data_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM loads/stores onto a byte-wide synchronous RAM,
// serializing each access into byte cycles and pulsing done to the winner.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic    clk_in,
  input  logic    rst_in,
  mem_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  owner_e            own_q, own_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        n_q, n_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;

  logic [31:0]       asm_data, ext_data;
  logic [2:0]        lane, idx_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^{bus.if_addr_in[31:ADDR_W], bus.mem_addr_in[31:ADDR_W]};

  assign idx_nx  = idx_q + 3'd1;
  assign addr_nx = addr_q + ADDR_W'(idx_nx);
  assign lane    = idx_q - 3'd1;

  // RAM data lags its address by one cycle, so byte i lands while idx_q == i+1.
  always_comb begin
    asm_data = rbuf_q;
    if (state_q == ST_READ && idx_q != 3'd0)
      asm_data[{lane[1:0], 3'b000} +: 8] = bus.ram_din_in;
  end

  mem_ctrl_load_extend u_ext (
    .data_i   (asm_data),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    addr_d      = addr_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    n_d         = n_q;
    rbuf_d      = rbuf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_a_d     = '0;
    ram_wr_d    = 1'b0;
    ram_dout_d  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        idx_d = 3'd0;
        if (bus.mem_req_in) begin
          own_d   = OWN_MEM;
          addr_d  = bus.mem_addr_in[ADDR_W-1:0];
          size_d  = bus.mem_size_in;
          sgn_d   = bus.mem_signed_in;
          wdata_d = bus.mem_wdata_in;
          n_d     = nbytes(bus.mem_size_in);
          ram_a_d = bus.mem_addr_in[ADDR_W-1:0];
          if (bus.mem_we_in) begin
            state_d    = ST_WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = bus.mem_wdata_in[7:0];
          end else begin
            state_d = ST_READ;
          end
        end else if (bus.if_req_in) begin
          own_d   = OWN_IF;
          addr_d  = bus.if_addr_in[ADDR_W-1:0];
          size_d  = SIZE_W;
          sgn_d   = 1'b0;
          n_d     = 3'd4;
          ram_a_d = bus.if_addr_in[ADDR_W-1:0];
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rbuf_d = asm_data;
        if (idx_q == n_q) begin
          state_d = ST_DONE;
          if (own_q == OWN_MEM) begin
            mem_rdata_d = ext_data;
            mem_done_d  = 1'b1;
          end else begin
            if_data_d = asm_data;
            if_done_d = 1'b1;
          end
        end else begin
          idx_d = idx_nx;
          if (idx_nx < n_q) ram_a_d = addr_nx;
        end
      end
      ST_WRITE: begin
        if (idx_nx == n_q) begin
          state_d    = ST_DONE;
          mem_done_d = 1'b1;
        end else begin
          idx_d      = idx_nx;
          ram_wr_d   = 1'b1;
          ram_a_d    = addr_nx;
          ram_dout_d = wdata_q[{idx_nx[1:0], 3'b000} +: 8];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      own_q       <= OWN_IF;
      addr_q      <= '0;
      size_q      <= SIZE_B;
      sgn_q       <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      rbuf_q      <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      rbuf_q      <= rbuf_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  assign bus.if_done_out   = if_done_q;
  assign bus.if_data_out   = if_data_q;
  assign bus.mem_done_out  = mem_done_q;
  assign bus.mem_rdata_out = mem_rdata_q;
  assign bus.ram_a_out     = ram_a_q;
  assign bus.ram_wr_out    = ram_wr_q;
  assign bus.ram_dout_out  = ram_dout_q;

endmodule
